// File: rtl/ffa_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of the GF(2^8) FFA unit.
// Optional zero-operand short-circuit: define FFA_SEQ_ZERO_CHECK_EN.
module ffa_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int INV_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [7:0]       ffa_operA,
  output logic [7:0]       ffa_operB,
  output logic [2:0]       ffa_op_sel,
  input  logic             ffa_busy,
  input  logic [7:0]       ffa_result
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(INV_TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(INV_TIMEOUT - 1);

  typedef struct packed {
    logic [2:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_INV
  } state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  state_t           state;
  logic [CW-1:0]    tmo;
  logic [TAG_W-1:0] cur_tag;
  logic             cur_zero;
  logic             push;
  logic             pop;
  logic             zero_hit;
  logic [2:0]       op_norm;

  assign push    = cmd_valid && cmd_ready;
  assign head    = mem[rd_ptr];
  assign pop     = (state == IDLE) && (count != '0)
                && (!res_valid || res_ready);
  assign op_norm = (head.op > 3'd4) ? 3'd0 : head.op;

`ifdef FFA_SEQ_ZERO_CHECK_EN
  assign zero_hit = ((op_norm == 3'd3) && (head.b == 8'd0))
                 || ((op_norm == 3'd4) && (head.a == 8'd0));
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      cmd_ready <= (count_nxt < FULL);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmo        <= '0;
      cur_tag    <= '0;
      cur_zero   <= 1'b0;
      ffa_operA  <= 8'd0;
      ffa_operB  <= 8'd0;
      ffa_op_sel <= 3'd0;
      res_valid  <= 1'b0;
      res_data   <= 8'd0;
      res_tag    <= '0;
      res_err    <= 1'b0;
    end else begin
      if (res_valid && res_ready)
        res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_tag  <= head.tag;
            cur_zero <= zero_hit;
            state    <= ISSUE;
            if (!zero_hit) begin
              ffa_operA  <= head.a;
              ffa_operB  <= head.b;
              ffa_op_sel <= op_norm;
            end
          end
        end
        ISSUE: begin
          if (cur_zero) begin
            res_data  <= 8'd0;
            res_err   <= 1'b1;
            res_tag   <= cur_tag;
            res_valid <= 1'b1;
            state     <= IDLE;
          end else if (ffa_op_sel == 3'd4) begin
            tmo   <= '0;
            state <= WAIT_INV;
          end else begin
            res_data   <= ffa_result;
            res_err    <= 1'b0;
            res_tag    <= cur_tag;
            res_valid  <= 1'b1;
            ffa_operA  <= 8'd0;
            ffa_operB  <= 8'd0;
            ffa_op_sel <= 3'd0;
            state      <= IDLE;
          end
        end
        WAIT_INV: begin
          tmo <= tmo + 1'b1;
          if (!ffa_busy || (tmo == TMO_LAST)) begin
            // busy still high on the last allowed cycle means abort
            res_data   <= ffa_busy ? 8'd0 : ffa_result;
            res_err    <= ffa_busy;
            res_tag    <= cur_tag;
            res_valid  <= 1'b1;
            ffa_operA  <= 8'd0;
            ffa_operB  <= 8'd0;
            ffa_op_sel <= 3'd0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
